audio_lpr_fir_decim: RTL and testbench

- Decimating low-pass FIR (L+R audio channel filter) directly downstream of `demod_top`.
- Pops demodulated 32-bit fixed-point samples from the demod output FIFO and filters them with a NUM_TAPS-tap constant-coefficient FIR.
- Emits one filtered sample per DECIM inputs into a downstream FIFO, feeding de-emphasis/volume.
- Arithmetic is bit-exact to the team's C fixed-point model: per-product dequantize, 32-bit wrapping sum.

---
 rtl/fm_radio_pkg.sv | 40 ++++
 rtl/audio_lpr_fir_decim_if.sv | 27 ++
 rtl/fir_decim_mac.sv | 49 ++++
 rtl/audio_lpr_fir_decim.sv | 109 ++++++++++
 tb/tb_audio_lpr_fir_decim.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fm_radio_pkg.sv
// Shared FM-radio constants: fixed-point format, L+R audio low-pass taps, dequantize helper.
// Consumers may enable FIR_DECIM_MULT_PIPE_EN to register the product before accumulation.
package fm_radio_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_TAPS   = 32;
  localparam int DECIM      = 8;
  localparam int BITS       = 10;

  localparam int TAP_W = $clog2(NUM_TAPS + 1);
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(DECIM);

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2
  } fir_state_e;

  localparam logic signed [DATA_WIDTH-1:0] AUDIO_LPR_COEFFS [NUM_TAPS] = '{
    32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
    32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
    32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
    32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
    32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
    32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
    32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
    32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
  };

  localparam logic signed [2*DATA_WIDTH-1:0] DEQ_BIAS = (2*DATA_WIDTH)'((64'sd1 <<< BITS) - 64'sd1);

  // Divide by 2^BITS rounding toward zero, matching C integer division in the reference model.
  function automatic logic signed [DATA_WIDTH-1:0] dequantize(input logic signed [2*DATA_WIDTH-1:0] p);
    logic signed [2*DATA_WIDTH-1:0] biased;
    biased = p[2*DATA_WIDTH-1] ? (p + DEQ_BIAS) : p;
    return DATA_WIDTH'(biased >>> BITS);
  endfunction

endpackage

// File: rtl/audio_lpr_fir_decim_if.sv
// FIFO-side bundle of the decimating FIR: upstream FWFT read port, downstream write port, state view.
// Unaffected by FIR_DECIM_MULT_PIPE_EN.
interface audio_lpr_fir_decim_if;
  import fm_radio_pkg::*;

  // Handshake: a word moves upstream->FIR on every rising edge with in_rd_en=1 (only
  // asserted while in_empty=0, data taken from in_dout in that same cycle); a word moves
  // FIR->downstream on every rising edge with out_wr_en=1 (only asserted while out_full=0).
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_full;
  logic                  out_wr_en;
  logic [1:0]            dbg_state;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en, dbg_state
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en, dbg_state
  );

endinterface

// File: rtl/fir_decim_mac.sv
// Multiply / dequantize / wrapping-accumulate datapath for the decimating FIR.
// FIR_DECIM_MULT_PIPE_EN adds a register between the dequantized product and the accumulator.
module fir_decim_mac
  import fm_radio_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] h_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [DATA_WIDTH-1:0] acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   deq_w;
  logic signed [DATA_WIDTH-1:0]   acc_q;
  logic signed [DATA_WIDTH-1:0]   acc_d;

  assign prod  = (2*DATA_WIDTH)'(h_i) * (2*DATA_WIDTH)'(x_i);
  assign deq_w = dequantize(prod);

`ifdef FIR_DECIM_MULT_PIPE_EN
  logic signed [DATA_WIDTH-1:0] prod_q;
  logic                         prod_vld_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_q     <= deq_w;
      prod_vld_q <= en_i & ~clr_i;
    end
  end

  assign acc_d = clr_i ? '0 : (prod_vld_q ? acc_q + prod_q : acc_q);
`else
  assign acc_d = clr_i ? '0 : (en_i ? acc_q + deq_w : acc_q);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/audio_lpr_fir_decim.sv
// L+R audio low-pass FIR with decimation: collects DECIM samples, runs one MAC pass, writes one output.
// FIR_DECIM_MULT_PIPE_EN stretches the MAC pass by one cycle for the product register.
module audio_lpr_fir_decim
  import fm_radio_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  audio_lpr_fir_decim_if.master bus
);

  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_MAC   = ST_MAC;
  localparam logic [1:0] S_WRITE = ST_WRITE;

`ifdef FIR_DECIM_MULT_PIPE_EN
  localparam logic [TAP_W-1:0] MAC_LAST = TAP_W'(NUM_TAPS);
`else
  localparam logic [TAP_W-1:0] MAC_LAST = TAP_W'(NUM_TAPS - 1);
`endif

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [TAP_W-1:0]             tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic                         pop;
  logic                         mac_clr;
  logic                         mac_en;
  logic                         wr_en;
  logic [IDX_W-1:0]             tap_idx;
  logic signed [DATA_WIDTH-1:0] acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    pop     = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_SHIFT: begin
        if (!bus.in_empty) begin
          pop = 1'b1;
          if (cnt_q == CNT_W'(DECIM - 1)) begin
            cnt_d   = '0;
            tap_d   = '0;
            mac_clr = 1'b1;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        // With the product register the final cycle only drains it, so no new tap is issued.
        mac_en = (tap_q < TAP_W'(NUM_TAPS));
        tap_d  = tap_q + 1'b1;
        if (tap_q == MAC_LAST) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.out_full) begin
          wr_en   = 1'b1;
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_SHIFT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SHIFT;
      cnt_q   <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
    end else if (pop) begin
      x_q[0] <= bus.in_dout;
      for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  assign tap_idx = tap_q[IDX_W-1:0];

  fir_decim_mac u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .h_i   (AUDIO_LPR_COEFFS[tap_idx]),
    .x_i   (x_q[tap_idx]),
    .acc_o (acc)
  );

  // The accumulator is frozen outside S_MAC, so it doubles as the registered output word.
  assign bus.out_din   = acc;
  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = wr_en;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_audio_lpr_fir_decim.sv
// Scoreboard bench for audio_lpr_fir_decim with hand-computed expected outputs.
// Runs with or without FIR_DECIM_MULT_PIPE_EN; only the expected write latency differs.
module tb_audio_lpr_fir_decim;

`ifdef FIR_DECIM_MULT_PIPE_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  localparam logic [1:0] ST_SHIFT = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic clock;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_writes;
  int   wr_cyc;
  int   cyc;
  int   last_pop_cyc;
  logic [31:0] exp_q[$];

  audio_lpr_fir_decim_if bus ();

  audio_lpr_fir_decim dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act, $signed(req), req);
    end
  endtask

  // monitor: pops the scoreboard on every downstream write
  initial begin
    logic [31:0] exp_v;
    n_writes = 0;
    wr_cyc   = 0;
    forever begin
      @(negedge clock);
      #1;
      if (rst_n && bus.out_wr_en) begin
        n_writes++;
        wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got out_wr_en with out_din=%0d, expected no write", $signed(bus.out_din));
        end else begin
          exp_v = exp_q.pop_front();
          check("out_din", bus.out_din, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic feed(input logic [31:0] v, input bit gap);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clock);
      bus.in_dout  = v;
      bus.in_empty = 1'b0;
      #1;
      if (bus.in_rd_en) begin
        done         = 1'b1;
        last_pop_cyc = cyc;
      end
      if (gap) begin
        @(negedge clock);
        bus.in_empty = 1'b1;
      end
      guard++;
      if (!done && guard > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL feed_timeout: got no pop in 1000 cycles, expected a pop");
        done = 1'b1;
      end
    end
  endtask

  task automatic feed_block(input logic [31:0] first, input logic [31:0] rest, input bit gap);
    feed(first, gap);
    for (int k = 1; k < 8; k++) feed(rest, gap);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_empty = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    rst_n = 1'b0;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    while (bus.dbg_state !== s && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(name, {30'b0, bus.dbg_state}, {30'b0, s});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  task automatic run_dc(input bit gap, input bit bp);
    int dc_exp [6] = '{-143, 2260, 4663, 4520, 4520, 4520};
    logic [31:0] held;
    int bad_wr, bad_rd, bad_din, w0;
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      exp_q.push_back(dc_exp[b]);
      feed_block(32'd1024, 32'd1024, gap);
      if (bp && b == 1) begin
        bus.out_full = 1'b1;
        idle();
        wait_state(ST_WRITE, "bp_reach_write");
        held    = bus.out_din;
        bad_wr  = 0;
        bad_rd  = 0;
        bad_din = 0;
        @(negedge clock);
        bus.in_dout  = 32'h0000_1234;
        bus.in_empty = 1'b0;
        repeat (100) begin
          @(negedge clock);
          #1;
          if (bus.out_wr_en)          bad_wr++;
          if (bus.in_rd_en)           bad_rd++;
          if (bus.out_din !== held)   bad_din++;
        end
        check("bp_wr_en_held_low", bad_wr, 0);
        check("bp_rd_en_held_low", bad_rd, 0);
        check("bp_out_din_stable", bad_din, 0);
        w0 = n_writes;
        @(negedge clock);
        bus.in_empty = 1'b1;
        bus.out_full = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        check("bp_single_write", n_writes - w0, 1);
      end
    end
    idle();
    wait_drain(gap ? "bursty_drain" : "dc_drain");
  endtask

  // main sequence
  initial begin
    int imp_exp [6] = '{-13, 579, 21, -3, 0, 0};
    int neg_exp [4] = '{19, -868, -31, 4};
    int wrap_exp [4] = '{299892736, -444596224, -1189085184, -889192448};
    int pop_c, w0;
    n_tests      = 0;
    n_fail       = 0;
    last_pop_cyc = 0;
    rst_n        = 1'b0;
    bus.in_dout  = '0;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_in_rd_en",  {31'b0, bus.in_rd_en},  32'd0);
    check("reset_out_wr_en", {31'b0, bus.out_wr_en}, 32'd0);
    check("reset_out_din",   bus.out_din,            32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // impulse of 1.0 picks out h[7], h[15], h[23], h[31]
    exp_q.push_back(imp_exp[0]);
    feed_block(32'd1024, 32'd0, 1'b0);
    pop_c = last_pop_cyc;
    idle();
    wait_drain("impulse_first_drain");
    check("write_latency", wr_cyc - pop_c, LAT);
    for (int b = 1; b < 6; b++) begin
      exp_q.push_back(imp_exp[b]);
      feed_block(32'd0, 32'd0, 1'b0);
    end
    idle();
    wait_drain("impulse_drain");

    run_dc(1'b0, 1'b1);
    run_dc(1'b1, 1'b0);

    // impulse of -1: every product truncates to 0, never -1
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(32'd0);
      feed_block(b == 0 ? 32'hffff_ffff : 32'd0, 32'd0, 1'b0);
    end
    idle();
    wait_drain("trunc_m1_drain");

    // impulse of -1.5: half-LSB products round toward zero
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(neg_exp[b]);
      feed_block(b == 0 ? 32'hffff_fa00 : 32'd0, 32'd0, 1'b0);
    end
    idle();
    wait_drain("trunc_m1p5_drain");

    // DC of -2^31: accumulator wraps modulo 2^32
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(wrap_exp[b]);
      feed_block(32'h8000_0000, 32'h8000_0000, 1'b0);
    end
    idle();
    wait_drain("wrap_drain");

    // reset at tap 10 of a MAC pass
    apply_reset();
    feed_block(32'd1024, 32'd1024, 1'b0);
    idle();
    wait_state(ST_MAC, "midrst_reach_mac");
    repeat (10) @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("midrst_state_shift", {30'b0, bus.dbg_state}, {30'b0, ST_SHIFT});
    w0 = n_writes;
    repeat (60) @(negedge clock);
    check("midrst_no_write", n_writes - w0, 0);
    exp_q.push_back(imp_exp[0]);
    feed_block(32'd1024, 32'd0, 1'b0);
    exp_q.push_back(imp_exp[1]);
    feed_block(32'd0, 32'd0, 1'b0);
    idle();
    wait_drain("midrst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
